// File: rtl/float_mult_pkg.sv
// float_mult_pkg: shared types, default widths and helper functions for the
// iterative minifloat multiplier (float_mult_seq).
package float_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } fm_state_e;

  localparam int unsigned FM_EXP_W = 4;
  localparam int unsigned FM_MAN_W = 3;

  // Standard excess bias for an exp_w-bit exponent field.
  function automatic int unsigned fm_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Largest finite magnitude: exponent and mantissa fields all ones.
  function automatic int unsigned fm_max_mag(input int unsigned exp_w,
                                             input int unsigned man_w);
    return (1 << (exp_w + man_w)) - 1;
  endfunction

endpackage

// File: rtl/float_mult_seq_if.sv
// float_mult_seq_if: operand/result valid-ready bundle for float_mult_seq.
// master = producer/consumer side, slave = multiplier side.
interface float_mult_seq_if #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 3
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );

endinterface

// File: rtl/float_mult_round.sv
// float_mult_round: combinational normalise / round / classify stage.
// Takes the raw mantissa product and unbiased-sum exponent and returns the
// packed result with overflow/underflow flags.
// Optional: FLOAT_MULT_RNE_EN selects round-to-nearest-even; otherwise the
// remainder is dropped (truncate toward zero).
module float_mult_round
  import float_mult_pkg::*;
#(
  parameter  int unsigned EXP_W = FM_EXP_W,
  parameter  int unsigned MAN_W = FM_MAN_W,
  localparam int unsigned W     = 1 + EXP_W + MAN_W,
  localparam int unsigned ACC_W = 2 * (MAN_W + 1),
  localparam int unsigned EW    = EXP_W + 2
) (
  input  logic                 i_sign,
  input  logic                 i_zero,
  input  logic [ACC_W-1:0]     i_acc,
  input  logic signed [EW-1:0] i_exp,
  output logic [W-1:0]         o_result,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic signed [EW-1:0] L_EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] L_EXP_MIN = EW'(1);

  logic                 w_msb;
  logic [MAN_W-1:0]     w_man;
  logic [MAN_W:0]       w_rem;
  logic signed [EW-1:0] w_exp_n;
  logic signed [EW-1:0] w_exp_r;
  logic                 w_carry;
  logic [MAN_W-1:0]     w_man_r;

  // Normalise: product is in [1,4); a set MSB means it is >= 2.
  // The remainder is left-aligned to MAN_W+1 bits so guard is always its MSB.
  always_comb begin
    w_msb = i_acc[ACC_W-1];
    if (w_msb) begin
      w_man = i_acc[2*MAN_W:MAN_W+1];
      w_rem = i_acc[MAN_W:0];
    end else begin
      w_man = i_acc[2*MAN_W-1:MAN_W];
      w_rem = {i_acc[MAN_W-1:0], 1'b0};
    end
    w_exp_n = i_exp + EW'(w_msb);
  end

`ifdef FLOAT_MULT_RNE_EN
  logic           w_guard;
  logic           w_sticky;
  logic           w_up;
  logic [MAN_W:0] w_sum;

  // Round to nearest, ties to even; a carry out wraps the mantissa to zero.
  always_comb begin
    w_guard  = w_rem[MAN_W];
    w_sticky = |w_rem[MAN_W-1:0];
    w_up     = w_guard & (w_sticky | w_man[0]);
    w_sum    = {1'b0, w_man} + (MAN_W + 1)'(w_up);
    w_carry  = w_sum[MAN_W];
    w_man_r  = w_sum[MAN_W-1:0];
  end
`else
  logic w_unused_rem;

  // Truncate toward zero: the remainder is discarded, no carry is possible.
  always_comb begin
    w_unused_rem = ^w_rem;
    w_carry      = 1'b0;
    w_man_r      = w_man;
  end
`endif

  // Classify: zero operand, then overflow, then underflow, else pack.
  always_comb begin
    w_exp_r     = w_exp_n + EW'(w_carry);
    o_result    = '0;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (i_zero) begin
      o_result = '0;
    end else if (w_exp_r > L_EXP_MAX) begin
      o_result   = {i_sign, (W - 1)'(fm_max_mag(EXP_W, MAN_W))};
      o_overflow = 1'b1;
    end else if (w_exp_r < L_EXP_MIN) begin
      o_underflow = 1'b1;
    end else begin
      o_result = {i_sign, w_exp_r[EXP_W-1:0], w_man_r};
    end
  end

endmodule

// File: rtl/float_mult_seq.sv
// float_mult_seq: iterative minifloat multiplier, one mantissa bit per cycle
// (shift-add), valid/ready on operands and result.
// Optional: FLOAT_MULT_RNE_EN (in float_mult_round) enables round-to-nearest-
// even; default build truncates.
module float_mult_seq
  import float_mult_pkg::*;
#(
  parameter int unsigned EXP_W = FM_EXP_W,
  parameter int unsigned MAN_W = FM_MAN_W,
  parameter int unsigned BIAS  = fm_bias(EXP_W)
) (
  input logic               clk,
  input logic               rst_n,
  float_mult_seq_if.slave   bus
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned P     = MAN_W + 1;
  localparam int unsigned ACC_W = 2 * P;
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned CNT_W = (P > 1) ? $clog2(P) : 1;

  fm_state_e            r_state;
  fm_state_e            w_next;
  logic                 r_sign;
  logic                 r_zero;
  logic signed [EW-1:0] r_exp;
  logic [P-1:0]         r_mand;
  logic [P-1:0]         r_mier;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [W-1:0]         r_result;
  logic                 r_ovf;
  logic                 r_udf;
  logic                 w_last;
  logic [W-1:0]         w_res;
  logic                 w_ovf;
  logic                 w_udf;

  assign w_last = (r_cnt == CNT_W'(MAN_W));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: accept, MAN_W+1 multiply steps, one normalise step, hold result.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = MUL;
      MUL:     if (w_last) w_next = NORM;
      NORM:    w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: handshakes decode the state; result/flags come from registers.
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    bus.result    = r_result;
    bus.overflow  = r_ovf;
    bus.underflow = r_udf;
  end

  // Datapath: latch operands, shift-add the mantissas, register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_exp    <= '0;
      r_mand   <= '0;
      r_mier   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sign <= bus.a[W-1] ^ bus.b[W-1];
            r_exp  <= EW'(bus.a[W-2:MAN_W]) + EW'(bus.b[W-2:MAN_W]) - EW'(BIAS);
            r_mand <= {1'b1, bus.a[MAN_W-1:0]};
            r_mier <= {1'b1, bus.b[MAN_W-1:0]};
            r_acc  <= '0;
            r_cnt  <= '0;
            r_zero <= (bus.a[W-2:0] == '0) || (bus.b[W-2:0] == '0);
          end
        end
        MUL: begin
          if (r_mier[r_cnt]) r_acc <= r_acc + (ACC_W'(r_mand) << r_cnt);
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        NORM: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_udf    <= w_udf;
        end
        default: ;
      endcase
    end
  end

  float_mult_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round (
    .i_sign     (r_sign),
    .i_zero     (r_zero),
    .i_acc      (r_acc),
    .i_exp      (r_exp),
    .o_result   (w_res),
    .o_overflow (w_ovf),
    .o_underflow(w_udf)
  );

endmodule
